st7066u_sequencer: RTL and testbench
====================================

# st7066u_sequencer

Sequencer for the ST7066U character LCD on the clock design. After power-up it runs the fixed HD44780-style init sequence, then repeatedly rewrites line 0 with the current time as "HH:MM:SS AM" or "HH:MM:SS PM". It drives the `ST7066U_data_output` byte register (enable, data/command, select, nibble) and generates the LCD RS/RW/E strobes with the required pulse-width and execution-time delays. Time inputs come from the clock counter; the LCD data bus is taken from the data_output register's `o_q`.

## Interface
Parameters:
- `POR_CYC`, 4_000_000: power-on wait before the first command (40 ms at 100 MHz).
- `E_CYC`, 50: E high width in cycles.
- `EXEC_CYC`, 5000: wait after E falls for normal commands and characters.
- `CLEAR_CYC`, 200_000: wait after E falls for Display Clear.
- `REFRESH_CYC`, 10_000_000: idle gap between frames.
- All parameters must be ≥1. Counters are 32 bits.

Ports:
- `i_clk` in 1: system clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_hour_t`, `i_hour_u`, `i_min_t`, `i_min_u`, `i_sec_t`, `i_sec_u` in 4 each: BCD time digits.
- `i_pm` in 1: 1 selects PM.
- `o_ena` out 1: one-cycle load strobe to the data_output register.
- `o_data` out 1: 1 selects character mode, 0 selects command mode.
- `o_sel` out 3: data_output select field.
- `o_d` out 4: data_output nibble.
- `o_lcd_rs` out 1: LCD register select.
- `o_lcd_rw` out 1: LCD read/write; tied to 0.
- `o_lcd_e` out 1: LCD enable strobe.
- `o_init_done` out 1: set after the 4th init command completes.

## Operation
- States:
  - POR_WAIT
  - LOAD
  - SETUP
  - E_HIGH
  - EXEC
  - REFRESH
- Step index `idx` runs 0..15. Each step is encoded as (`o_data`, `o_sel`, `o_d`):
  - Init steps:
    - 0: (0,100,0), Function Set 0x38.
    - 1: (0,101,0), Display On 0x0C.
    - 2: (0,110,0), Clear 0x01.
    - 3: (0,111,0), Entry Mode 0x06.
  - Frame steps:
    - 4: (0,000,0), set address 0x80.
    - 5: (1,000,hour_t).
    - 6: (1,000,hour_u).
    - 7: (1,001,0), ':'.
    - 8: (1,000,min_t).
    - 9: (1,000,min_u).
    - 10: (1,001,0), ':'.
    - 11: (1,000,sec_t).
    - 12: (1,000,sec_u).
    - 13: (1,001,1), ' '.
    - 14: (1,011,{3'b0,pm}), 'P' or 'A'.
    - 15: (1,010,0), 'M'.
- Snapshot: all seven time inputs are registered when step 4 enters LOAD. Steps 5–15 use only the snapshot, so each frame is internally coherent.
- Transitions:
  - Reset → POR_WAIT, `idx`=0.
  - POR_WAIT lasts `POR_CYC` cycles, then → LOAD.
  - LOAD lasts 1 cycle. `o_ena`=1 and the fields take the value for `idx`. Then → SETUP.
  - SETUP lasts 1 cycle. The data_output register is now valid. `o_lcd_e`=0. Then → E_HIGH.
  - E_HIGH lasts `E_CYC` cycles with `o_lcd_e`=1. Then → EXEC.
  - EXEC waits `CLEAR_CYC` cycles if `idx`==2, otherwise `EXEC_CYC` cycles. Then:
    - if `idx`==15 → REFRESH;
    - otherwise `idx`+1 → LOAD.
  - REFRESH lasts `REFRESH_CYC` cycles, then `idx`=4 → LOAD. Init is never repeated except after reset.
- `o_lcd_rs` equals `o_data` and changes only in LOAD. `o_data`, `o_sel` and `o_d` hold stable from LOAD until the next LOAD.
- `o_init_done` is set at the end of EXEC for `idx`==3. It stays 1 until reset.
- Input digits are not range-checked; values above 9 pass through as nibble codes.

## Timing
- Reset values:
  - All outputs are 0.
  - State is POR_WAIT, `idx`=0, all counters 0.
- `i_rst_n` low at any time, including mid E-high: all outputs drop to 0 asynchronously. Release causes a full restart from POR_WAIT.
- Step duration:
  - normal: `2 + E_CYC + EXEC_CYC` cycles;
  - clear: `2 + E_CYC + CLEAR_CYC` cycles.
- First `o_ena` occurs in cycle `POR_CYC` after reset release (cycle 0 = first clock edge with `i_rst_n`=1).
- RS is valid 1 cycle before E rises (SETUP) and is held through EXEC.
- `o_ena` and `o_lcd_e` are never high in the same cycle.
- Frame period: 12 steps + `REFRESH_CYC` cycles.

## Test plan
Bench uses `POR_CYC`=10, `E_CYC`=2, `EXEC_CYC`=4, `CLEAR_CYC`=8, `REFRESH_CYC`=20, with a data_output model on the outputs.
- Reset release → all outputs 0 for 10 cycles, then `o_ena`=1 with `o_data`=0, `o_sel`=100. Model `o_q`=0x38 in the next cycle.
- Init sequence → bytes 0x38, 0x0C, 0x01, 0x06 in order. Each E pulse is 2 cycles.
  - LOAD-to-LOAD spacing is 8 cycles, except 12 cycles after Clear.
  - `o_init_done` rises 4 cycles after the 4th E falls.
- Digits 1,2,3,4,5,6 with `i_pm`=1 → RS=0 byte 0x80, then RS=1 bytes 0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36 0x20 0x50 0x4D. With `i_pm`=0, byte 11 is 0x41.
- Change digits to 9,9,5,9,5,9 during step 8 → current frame still emits "12:34:56". The next frame emits "99:59:59".
- After 'M' EXEC ends → no `o_ena`/E activity for exactly 20 cycles. Next LOAD is address 0x80, not 0x38.
- Assert `i_rst_n`=0 during E_HIGH of step 9 → `o_lcd_e` and `o_init_done` are 0 immediately. After release, a 10-cycle POR wait is followed by 0x38.

Source files
------------

// File: rtl/st7066u_sequencer_if.sv
// Output bundle of the ST7066U sequencer: data_output register load fields plus LCD strobes.
interface st7066u_sequencer_if;
    logic       o_ena;
    logic       o_data;
    logic [2:0] o_sel;
    logic [3:0] o_d;
    logic       o_lcd_rs;
    logic       o_lcd_rw;
    logic       o_lcd_e;
    logic       o_init_done;

    modport master (
        output o_ena, o_data, o_sel, o_d, o_lcd_rs, o_lcd_rw, o_lcd_e, o_init_done
    );

    modport slave (
        input o_ena, o_data, o_sel, o_d, o_lcd_rs, o_lcd_rw, o_lcd_e, o_init_done
    );
endinterface

// File: rtl/st7066u_sequencer.sv
// ST7066U character LCD sequencer: power-on init, then periodic rewrite of line 0 with
// "HH:MM:SS AM/PM" through the data_output register, with RS/RW/E strobe timing.
module st7066u_sequencer #(
    parameter int unsigned POR_CYC     = 4_000_000,
    parameter int unsigned E_CYC       = 50,
    parameter int unsigned EXEC_CYC    = 5000,
    parameter int unsigned CLEAR_CYC   = 200_000,
    parameter int unsigned REFRESH_CYC = 10_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [3:0]           i_hour_t,
    input  logic [3:0]           i_hour_u,
    input  logic [3:0]           i_min_t,
    input  logic [3:0]           i_min_u,
    input  logic [3:0]           i_sec_t,
    input  logic [3:0]           i_sec_u,
    input  logic                 i_pm,
    st7066u_sequencer_if.master  lcd
);

    localparam logic [31:0] PorLim     = 32'(POR_CYC - 1);
    localparam logic [31:0] ELim       = 32'(E_CYC - 1);
    localparam logic [31:0] ExecLim    = 32'(EXEC_CYC - 1);
    localparam logic [31:0] ClearLim   = 32'(CLEAR_CYC - 1);
    localparam logic [31:0] RefreshLim = 32'(REFRESH_CYC - 1);

    typedef enum logic [2:0] {
        StPorWait,
        StLoad,
        StSetup,
        StEHigh,
        StExec,
        StRefresh
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        init_done_q, init_done_d;
    logic [31:0] exec_lim;

    logic        data_q;
    logic [2:0]  sel_q;
    logic [3:0]  d_q;
    logic        f_data;
    logic [2:0]  f_sel;
    logic [3:0]  f_d;

    logic [3:0]  hour_t_q, hour_u_q, min_t_q, min_u_q, sec_t_q, sec_u_q;
    logic        pm_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StPorWait;
            cnt_q       <= '0;
            idx_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
        end
    end

    assign exec_lim = (idx_q == 4'd2) ? ClearLim : ExecLim;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        case (state_q)
            StPorWait: begin
                if (cnt_q == PorLim) begin
                    cnt_d   = '0;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StLoad:  state_d = StSetup;
            StSetup: state_d = StEHigh;
            StEHigh: begin
                if (cnt_q == ELim) begin
                    cnt_d   = '0;
                    state_d = StExec;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StExec: begin
                if (cnt_q == exec_lim) begin
                    cnt_d = '0;
                    if (idx_q == 4'd3) begin
                        init_done_d = 1'b1;
                    end
                    if (idx_q == 4'd15) begin
                        state_d = StRefresh;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StLoad;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StRefresh: begin
                if (cnt_q == RefreshLim) begin
                    cnt_d   = '0;
                    idx_d   = 4'd4;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = StPorWait;
        endcase
    end

    // Fields for the step about to enter LOAD; steps 5..15 read only the frame snapshot.
    always_comb begin
        f_data = 1'b0;
        f_sel  = 3'b000;
        f_d    = 4'h0;
        unique case (idx_d)
            4'd0:  begin f_data = 1'b0; f_sel = 3'b100; f_d = 4'h0; end
            4'd1:  begin f_data = 1'b0; f_sel = 3'b101; f_d = 4'h0; end
            4'd2:  begin f_data = 1'b0; f_sel = 3'b110; f_d = 4'h0; end
            4'd3:  begin f_data = 1'b0; f_sel = 3'b111; f_d = 4'h0; end
            4'd4:  begin f_data = 1'b0; f_sel = 3'b000; f_d = 4'h0; end
            4'd5:  begin f_data = 1'b1; f_sel = 3'b000; f_d = hour_t_q; end
            4'd6:  begin f_data = 1'b1; f_sel = 3'b000; f_d = hour_u_q; end
            4'd7:  begin f_data = 1'b1; f_sel = 3'b001; f_d = 4'h0; end
            4'd8:  begin f_data = 1'b1; f_sel = 3'b000; f_d = min_t_q; end
            4'd9:  begin f_data = 1'b1; f_sel = 3'b000; f_d = min_u_q; end
            4'd10: begin f_data = 1'b1; f_sel = 3'b001; f_d = 4'h0; end
            4'd11: begin f_data = 1'b1; f_sel = 3'b000; f_d = sec_t_q; end
            4'd12: begin f_data = 1'b1; f_sel = 3'b000; f_d = sec_u_q; end
            4'd13: begin f_data = 1'b1; f_sel = 3'b001; f_d = 4'h1; end
            4'd14: begin f_data = 1'b1; f_sel = 3'b011; f_d = {3'b000, pm_q}; end
            4'd15: begin f_data = 1'b1; f_sel = 3'b010; f_d = 4'h0; end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q   <= 1'b0;
            sel_q    <= 3'b000;
            d_q      <= 4'h0;
            hour_t_q <= 4'h0;
            hour_u_q <= 4'h0;
            min_t_q  <= 4'h0;
            min_u_q  <= 4'h0;
            sec_t_q  <= 4'h0;
            sec_u_q  <= 4'h0;
            pm_q     <= 1'b0;
        end else if (state_d == StLoad) begin
            data_q <= f_data;
            sel_q  <= f_sel;
            d_q    <= f_d;
            if (idx_d == 4'd4) begin
                hour_t_q <= i_hour_t;
                hour_u_q <= i_hour_u;
                min_t_q  <= i_min_t;
                min_u_q  <= i_min_u;
                sec_t_q  <= i_sec_t;
                sec_u_q  <= i_sec_u;
                pm_q     <= i_pm;
            end
        end
    end

    always_comb begin
        lcd.o_ena       = (state_q == StLoad);
        lcd.o_lcd_e     = (state_q == StEHigh);
        lcd.o_data      = data_q;
        lcd.o_lcd_rs    = data_q;
        lcd.o_lcd_rw    = 1'b0;
        lcd.o_sel       = sel_q;
        lcd.o_d         = d_q;
        lcd.o_init_done = init_done_q;
    end

endmodule

// File: tb/tb_st7066u_sequencer.sv
// Bench for st7066u_sequencer: data_output register model feeding a byte scoreboard,
// plus directed timing checks on POR, step spacing, refresh gap and async reset.
module tb_st7066u_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [3:0] i_hour_t, i_hour_u, i_min_t, i_min_u, i_sec_t, i_sec_u;
    logic       i_pm;

    st7066u_sequencer_if lcd_if ();

    st7066u_sequencer #(
        .POR_CYC     (10),
        .E_CYC       (2),
        .EXEC_CYC    (4),
        .CLEAR_CYC   (8),
        .REFRESH_CYC (20)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_hour_t (i_hour_t),
        .i_hour_u (i_hour_u),
        .i_min_t  (i_min_t),
        .i_min_u  (i_min_u),
        .i_sec_t  (i_sec_t),
        .i_sec_u  (i_sec_u),
        .i_pm     (i_pm),
        .lcd      (lcd_if)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int overlap = 0;
    int e_rise_cyc = 0;
    int e_fall_cyc = 0;
    int init_gap = -1;
    logic e_prev = 1'b0;
    logic init_prev = 1'b0;
    logic [7:0] model_q;
    logic [8:0] exp_q[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [7:0] model_byte(input logic data, input logic [2:0] sel,
                                              input logic [3:0] d);
        if (!data) begin
            case (sel)
                3'b000:  return 8'h80;
                3'b100:  return 8'h38;
                3'b101:  return 8'h0C;
                3'b110:  return 8'h01;
                3'b111:  return 8'h06;
                default: return 8'h00;
            endcase
        end
        case (sel)
            3'b000:  return {4'h3, d};
            3'b001:  return d[0] ? 8'h20 : 8'h3A;
            3'b010:  return 8'h4D;
            3'b011:  return d[0] ? 8'h50 : 8'h41;
            default: return 8'h3F;
        endcase
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) model_q <= 8'h00;
        else if (lcd_if.o_ena) model_q <= model_byte(lcd_if.o_data, lcd_if.o_sel, lcd_if.o_d);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int ht, input int hu, input int mt, input int mu,
                              input int st, input int su, input logic pm);
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b1, 8'(8'h30 + ht)});
        exp_q.push_back({1'b1, 8'(8'h30 + hu)});
        exp_q.push_back({1'b1, 8'h3A});
        exp_q.push_back({1'b1, 8'(8'h30 + mt)});
        exp_q.push_back({1'b1, 8'(8'h30 + mu)});
        exp_q.push_back({1'b1, 8'h3A});
        exp_q.push_back({1'b1, 8'(8'h30 + st)});
        exp_q.push_back({1'b1, 8'(8'h30 + su)});
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b1, pm ? 8'h50 : 8'h41});
        exp_q.push_back({1'b1, 8'h4D});
    endtask

    task automatic wait_ena(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge i_clk);
            #1;
            if (lcd_if.o_ena) begin
                at = cyc;
                break;
            end
        end
        n_checks++;
        assert (at >= 0) else begin
            n_errors++;
            $error("FAIL ena_timeout: observed no o_ena expected one within 200 cycles");
        end
    endtask

    // Byte at each E rise is popped from the scoreboard; E width and init_done timing tracked.
    always @(posedge i_clk) begin
        #1;
        if (!i_rst_n) begin
            e_prev    = 1'b0;
            init_prev = 1'b0;
        end else begin
            if (lcd_if.o_ena && lcd_if.o_lcd_e) overlap++;
            if (lcd_if.o_lcd_e && !e_prev) begin
                e_rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("byte_unexpected", {23'd0, lcd_if.o_lcd_rs, model_q}, 32'hFFFF_FFFF);
                end else begin
                    check("lcd_byte", {23'd0, lcd_if.o_lcd_rs, model_q},
                          {23'd0, exp_q.pop_front()});
                end
            end
            if (!lcd_if.o_lcd_e && e_prev) begin
                check("e_width", cyc - e_rise_cyc, 2);
                e_fall_cyc = cyc;
            end
            if (lcd_if.o_init_done && !init_prev) init_gap = cyc - e_fall_cyc;
            e_prev    = lcd_if.o_lcd_e;
            init_prev = lcd_if.o_init_done;
        end
    end

    initial begin
        int rel, zero_bad;
        int c0, c1, c2, c3, c4, c5, cl, cn, c;

        i_rst_n  = 1'b0;
        i_hour_t = 4'd1; i_hour_u = 4'd2; i_min_t = 4'd3;
        i_min_u  = 4'd4; i_sec_t  = 4'd5; i_sec_u = 4'd6;
        i_pm     = 1'b1;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
        push_frame(1, 2, 3, 4, 5, 6, 1'b1);

        repeat (3) @(negedge i_clk);
        check("reset_outputs", {lcd_if.o_ena, lcd_if.o_data, lcd_if.o_sel, lcd_if.o_d,
                                lcd_if.o_lcd_rs, lcd_if.o_lcd_rw, lcd_if.o_lcd_e,
                                lcd_if.o_init_done}, 0);

        @(negedge i_clk);
        i_rst_n = 1'b1;
        rel = cyc;
        zero_bad = 0;
        repeat (9) begin
            @(posedge i_clk);
            #1;
            if (lcd_if.o_ena || lcd_if.o_lcd_e || lcd_if.o_data || lcd_if.o_sel != 3'b000 ||
                lcd_if.o_d != 4'h0 || lcd_if.o_lcd_rs || lcd_if.o_init_done) zero_bad++;
        end
        check("por_quiet", zero_bad, 0);
        @(posedge i_clk);
        #1;
        check("first_load", {lcd_if.o_ena, lcd_if.o_data, lcd_if.o_sel}, {1'b1, 1'b0, 3'b100});
        c0 = cyc;
        check("por_len", c0 - rel, 10);
        @(posedge i_clk);
        #1;
        check("model_q_38", model_q, 8'h38);

        wait_ena(c1); check("gap_func_set", c1 - c0, 8);
        wait_ena(c2); check("gap_disp_on", c2 - c1, 8);
        wait_ena(c3); check("gap_clear", c3 - c2, 12);
        wait_ena(c4); check("gap_entry", c4 - c3, 8);
        @(negedge i_clk);
        check("init_done_set", lcd_if.o_init_done, 1);
        check("init_done_gap", init_gap, 4);

        wait_ena(c5); check("gap_frame", c5 - c4, 8);
        repeat (3) wait_ena(c);
        // Now in step 8 of frame 1: the new digits must only show in the next frame.
        i_hour_t = 4'd9; i_hour_u = 4'd9; i_min_t = 4'd5;
        i_min_u  = 4'd9; i_sec_t  = 4'd5; i_sec_u = 4'd9;
        i_pm     = 1'b0;
        push_frame(9, 9, 5, 9, 5, 9, 1'b0);

        repeat (7) wait_ena(cl);
        wait_ena(cn);
        check("refresh_gap", cn - cl, 28);
        check("addr_cmd", {lcd_if.o_data, lcd_if.o_sel, lcd_if.o_d}, 0);

        repeat (5) wait_ena(c);
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk);
            #1;
            if (lcd_if.o_lcd_e) break;
        end
        @(negedge i_clk);
        check("e_high_step9", lcd_if.o_lcd_e, 1);
        i_rst_n = 1'b0;
        #1;
        check("reset_mid_e", {lcd_if.o_lcd_e, lcd_if.o_init_done, lcd_if.o_ena, lcd_if.o_data,
                              lcd_if.o_sel, lcd_if.o_d, lcd_if.o_lcd_rs}, 0);
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h38});

        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        rel = cyc;
        wait_ena(c);
        check("por_after_reset", c - rel, 10);
        check("restart_func_set", {lcd_if.o_data, lcd_if.o_sel}, {1'b0, 3'b100});
        repeat (6) @(posedge i_clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        check("ena_e_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
